seq_shift_unit: RTL and testbench
=================================

Name: seq_shift_unit

Overview:
- Multi-cycle shift unit for the MIPS datapath; executes SLL, SRL, SRA and ROTR on a 32-bit operand.
- Complements the fixed left-by-2 offset shifter by providing right-direction and variable-amount shifts.
- Iterates at most 2 bit positions per cycle, so the logic is a narrow 2-step shifter instead of a full barrel shifter.
- Sits beside the ALU; the control unit starts it with a start/done handshake and stalls while busy.

Parameters:
- WIDTH, 32, data width in bits.
- SHW, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  clock; rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- op  input  2  00=SLL, 01=SRL, 10=SRA, 11=ROTR (rotate right).
- in_data  input  WIDTH  operand; latched when start is accepted.
- shamt  input  SHW  shift amount, 0..WIDTH-1; latched when start is accepted.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; out_data is valid.
- out_data  output  WIDTH  result; held until the next accepted start.

Behaviour:
- Reset (asynchronous, any time, including mid-operation): state=IDLE, busy=0, done=0, out_data=0, internal data/count/op cleared. No partial result survives reset.
- States:
  - IDLE: wait for start.
  - SHIFT: iterate.
  - DONE: one cycle; done=1, busy=0.
- Accepting start (IDLE or DONE, start=1 at a rising edge):
  - Latch in_data, op and shamt (into rem).
  - Next state = SHIFT if shamt!=0, otherwise DONE.
- Back-to-back operation: start accepted in DONE loads the new operation directly, so done can be followed by a new busy with no idle gap.
- start while in SHIFT is ignored; no queueing.
- SHIFT, each edge:
  - Step k = 2 if rem>=2, else 1.
  - Apply op by k to the working register; rem -= k.
  - When rem reaches 0, next state = DONE and out_data is loaded from the working register on that same edge.
- Step rules per op:
  - SLL: zero-fill at the LSB end.
  - SRL: zero-fill at the MSB end.
  - SRA: fill with the original bit WIDTH-1 (sign preserved across all steps).
  - ROTR: bits leaving the LSB re-enter at the MSB.
- DONE: done=1 for exactly one cycle, then return to IDLE unless a new start is accepted.
- Latency: with n = latched shamt, done is high in the cycle after edge ceil(n/2)+1 counted from the accepting edge. Examples: n=0 gives 1, n=1 gives 2, n=31 gives 17.
- shamt=0: out_data = in_data for every op.
- out_data changes only on the edge entering DONE or on reset; it is stable during busy.
- op and in_data may change freely after acceptance; only latched copies are used.

Test Plan:
- SLL, in_data=0x00000002, shamt=2 -> done 2 cycles after accept, out_data=0x00000008; busy high for exactly 1 cycle.
- SRA, in_data=0xF0F0F0F0, shamt=5 -> 3 SHIFT cycles, done at cycle 4, out_data=0xFF878787.
- SRL, in_data=0xFFFFFFFF, shamt=31 -> done at cycle 17, out_data=0x00000001; SRA with the same operands -> 0xFFFFFFFF.
- ROTR, in_data=0x12341234, shamt=8 -> out_data=0x34123412 at cycle 5. A second start issued during the first operation's DONE cycle (SLL, 0x00000010, shamt=4) is accepted and yields 0x00000100 at cycle 3 after that edge.
- shamt=0, in_data=0x00000010, op=SRA -> done after 1 cycle, busy never asserted, out_data=0x00000010. A start pulse raised mid-SHIFT on a shamt=20 operation is ignored and the original result is unchanged.
- Assert reset for 1 cycle mid-SHIFT (SRL 0x12341234, shamt=30) -> busy=0, done=0, out_data=0 immediately. A following SLL 0x1, shamt=31 completes normally with 0x80000000 at cycle 17.

Source files
------------

// File: rtl/seq_shift_if.sv
// Start/done handshake between the control unit and the multi-cycle shift unit.
// The master issues operations; the slave (shift unit) reports busy/done/result.
interface seq_shift_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   shamt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out_data;

    modport master (
        output start, op, in_data, shamt,
        input  busy, done, out_data
    );

    modport slave (
        input  start, op, in_data, shamt,
        output busy, done, out_data
    );
endinterface

// File: rtl/seq_shift_unit.sv
// Multi-cycle SLL/SRL/SRA/ROTR unit: advances at most two bit positions per cycle.
// Result is loaded on the edge entering DONE and held until the next accepted start.
module seq_shift_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input  logic        clk_i,
    input  logic        reset_i,
    seq_shift_if.slave  bus_io
);
    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d, out_q, out_d, stepped;
    logic [SHW-1:0]   rem_q, rem_d, step_k;
    logic [1:0]       op_q, op_d;
    logic             sign_q, sign_d;
    logic             accept, two_step, last_step;

    assign accept    = bus_io.start && (state_q == StIdle || state_q == StDone);
    assign two_step  = rem_q >= SHW'(2);
    assign last_step = rem_q <= SHW'(2);
    assign step_k    = two_step ? SHW'(2) : SHW'(1);

    // op encoding: 00 SLL, 01 SRL, 10 SRA (fill with latched sign), 11 ROTR
    always_comb begin
        stepped = work_q;
        unique case (op_q)
            2'b00: stepped = two_step ? {work_q[WIDTH-3:0], 2'b00}
                                      : {work_q[WIDTH-2:0], 1'b0};
            2'b01: stepped = two_step ? {2'b00, work_q[WIDTH-1:2]}
                                      : {1'b0, work_q[WIDTH-1:1]};
            2'b10: stepped = two_step ? {{2{sign_q}}, work_q[WIDTH-1:2]}
                                      : {sign_q, work_q[WIDTH-1:1]};
            2'b11: stepped = two_step ? {work_q[1:0], work_q[WIDTH-1:2]}
                                      : {work_q[0], work_q[WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (bus_io.start) begin
                    state_d = (bus_io.shamt != '0) ? StShift : StDone;
                end else begin
                    state_d = StIdle;
                end
            end
            StShift: if (last_step) state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        work_d = work_q;
        rem_d  = rem_q;
        op_d   = op_q;
        sign_d = sign_q;
        out_d  = out_q;
        if (accept) begin
            work_d = bus_io.in_data;
            rem_d  = bus_io.shamt;
            op_d   = bus_io.op;
            sign_d = bus_io.in_data[WIDTH-1];
            if (bus_io.shamt == '0) out_d = bus_io.in_data;
        end else if (state_q == StShift) begin
            work_d = stepped;
            rem_d  = rem_q - step_k;
            if (last_step) out_d = stepped;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            work_q <= '0;
            rem_q  <= '0;
            op_q   <= '0;
            sign_q <= 1'b0;
            out_q  <= '0;
        end else begin
            work_q <= work_d;
            rem_q  <= rem_d;
            op_q   <= op_d;
            sign_q <= sign_d;
            out_q  <= out_d;
        end
    end

    always_comb begin
        bus_io.busy     = (state_q == StShift);
        bus_io.done     = (state_q == StDone);
        bus_io.out_data = out_q;
    end
endmodule

// File: tb/tb_seq_shift_unit.sv
// Self-checking bench for seq_shift_unit: vector table, random ops against a
// reference model, back-to-back start, ignored mid-shift start and mid-shift reset.
module tb_seq_shift_unit;
    localparam int unsigned W = 32;
    localparam int unsigned S = 5;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] data;
        logic [S-1:0] sh;
        logic [W-1:0] exp;
    } vec_t;

    typedef struct {
        logic [W-1:0] out;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [W-1:0] last_out;
    exp_t sb[$];
    vec_t vecs[12];

    always #5 clk = ~clk;

    seq_shift_if #(.WIDTH(W), .SHW(S)) bus ();

    seq_shift_unit #(.WIDTH(W), .SHW(S)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus_io  (bus)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_shift(input logic [1:0] op, input logic [W-1:0] d,
                                               input logic [S-1:0] n);
        logic [2*W-1:0] t;
        case (op)
            2'd0: return d << n;
            2'd1: return d >> n;
            2'd2: return W'($signed(d) >>> n);
            default: begin
                t = {d, d} >> n;
                return t[W-1:0];
            end
        endcase
    endfunction

    // Issue one op at the current negedge, then wait for done; poke>0 raises start
    // again during SHIFT at that cycle index to prove it is ignored.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] data, input logic [S-1:0] sh,
                          input logic [W-1:0] exp_out, input int poke);
        exp_t e;
        int   cyc;
        int   busy_cnt;
        e.out = exp_out;
        e.lat = (int'(sh) + 1) / 2 + 1;
        sb.push_back(e);
        bus.start   = 1'b1;
        bus.op      = op;
        bus.in_data = data;
        bus.shamt   = sh;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.op      = ~op;
        bus.in_data = ~data;
        bus.shamt   = ~sh;
        busy_cnt    = 0;
        while (!bus.done && cyc < 40) begin
            if (bus.busy) busy_cnt++;
            chk("out_hold_during_busy", bus.out_data, last_out);
            bus.start = (cyc == poke);
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        if (!bus.done) begin
            chk("done_timeout", W'(bus.done), W'(1));
            sb.delete();
        end else begin
            e = sb.pop_front();
            chk("out_data", bus.out_data, e.out);
            chk("latency", W'(cyc), W'(e.lat));
            chk("busy_cycles", W'(busy_cnt), W'(e.lat - 1));
            chk("busy_in_done", W'(bus.busy), W'(0));
        end
        last_out = exp_out;
    endtask

    initial begin
        vecs[0]  = '{2'd0, 32'h0000_0002, 5'd2,  32'h0000_0008};
        vecs[1]  = '{2'd2, 32'hF0F0_F0F0, 5'd5,  32'hFF87_8787};
        vecs[2]  = '{2'd1, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001};
        vecs[3]  = '{2'd3, 32'h1234_1234, 5'd8,  32'h3412_3412};
        vecs[4]  = '{2'd0, 32'h0000_0010, 5'd4,  32'h0000_0100};
        vecs[5]  = '{2'd2, 32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFF};
        vecs[6]  = '{2'd2, 32'h0000_0010, 5'd0,  32'h0000_0010};
        vecs[7]  = '{2'd1, 32'h8000_0000, 5'd1,  32'h4000_0000};
        vecs[8]  = '{2'd3, 32'h0000_0001, 5'd1,  32'h8000_0000};
        vecs[9]  = '{2'd2, 32'h8000_0000, 5'd3,  32'hF000_0000};
        vecs[10] = '{2'd3, 32'h0000_0003, 5'd31, 32'h0000_0006};
        vecs[11] = '{2'd0, 32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFF};

        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.op      = '0;
        bus.in_data = '0;
        bus.shamt   = '0;
        last_out    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset_busy", W'(bus.busy), W'(0));
        chk("reset_done", W'(bus.done), W'(0));
        chk("reset_out", bus.out_data, W'(0));

        // Odd entries chain straight into the next start during DONE.
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].data, vecs[i].sh, vecs[i].exp, 0);
            if (i % 2 == 0) begin
                @(posedge clk);
                @(negedge clk);
                chk("done_single_pulse", W'(bus.done), W'(0));
                chk("idle_busy", W'(bus.busy), W'(0));
                chk("idle_out_hold", bus.out_data, last_out);
            end
        end

        run_op(2'd0, 32'h0000_0001, 5'd20, 32'h0010_0000, 3);

        for (int i = 0; i < 8; i++) begin
            logic [1:0]   rop;
            logic [W-1:0] rd;
            logic [S-1:0] rs;
            rop = 2'($urandom_range(0, 3));
            rd  = $urandom;
            rs  = S'($urandom_range(0, 31));
            run_op(rop, rd, rs, ref_shift(rop, rd, rs), 0);
        end

        // Asynchronous reset in the middle of a long shift.
        bus.start   = 1'b1;
        bus.op      = 2'd1;
        bus.in_data = 32'h1234_1234;
        bus.shamt   = 5'd30;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("busy_before_reset", W'(bus.busy), W'(1));
        reset = 1'b1;
        #1;
        chk("async_reset_busy", W'(bus.busy), W'(0));
        chk("async_reset_done", W'(bus.done), W'(0));
        chk("async_reset_out", bus.out_data, W'(0));
        @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        last_out = '0;
        chk("post_reset_out", bus.out_data, W'(0));
        run_op(2'd0, 32'h0000_0001, 5'd31, 32'h8000_0000, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
